stopwatch_lap_timer: RTL and testbench

//  Parametrised next-generation stopwatch core. Counts hh:mm:ss.cc up (stopwatch) or down from a preset (timer).

---
 rtl/time_pkg.sv | 74 +++++++
 rtl/tick_gen.sv | 29 ++
 rtl/stopwatch_lap_timer.sv | 162 ++++++++++++++++
 tb/tb_stopwatch_lap_timer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - shared state encoding, time field widths and carry/borrow helpers
package time_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      STOP    = 2'd2,
      EXPIRED = 2'd3
   } state_t;

   localparam int MSEC_MAX = 99;
   localparam int SEC_MAX  = 59;
   localparam int MIN_MAX  = 59;

   localparam int MSEC_W  = 7;
   localparam int SEC_W   = 6;
   localparam int MIN_W   = 6;
   // Hour storage is sized for the widest supported HOUR_W (<= 8); the top narrows it.
   localparam int HOUR_FW = 8;

   typedef struct packed {
      logic [HOUR_FW-1:0] hour;
      logic [MIN_W-1:0]   min;
      logic [SEC_W-1:0]   sec;
      logic [MSEC_W-1:0]  msec;
   } time_t;

   // One tick forward with carries; hour wraps from hour_max to 0.
   function automatic time_t time_inc(input time_t t, input logic [HOUR_FW-1:0] hour_max);
      time_t r;
      r = t;
      if (t.msec != MSEC_W'(MSEC_MAX)) begin
         r.msec = t.msec + 1'b1;
      end else begin
         r.msec = '0;
         if (t.sec != SEC_W'(SEC_MAX)) begin
            r.sec = t.sec + 1'b1;
         end else begin
            r.sec = '0;
            if (t.min != MIN_W'(MIN_MAX)) begin
               r.min = t.min + 1'b1;
            end else begin
               r.min  = '0;
               r.hour = (t.hour == hour_max) ? '0 : t.hour + 1'b1;
            end
         end
      end
      return r;
   endfunction

   // One tick backward with borrows; callers never pass an all-zero time.
   function automatic time_t time_dec(input time_t t, input logic [HOUR_FW-1:0] hour_max);
      time_t r;
      r = t;
      if (t.msec != '0) begin
         r.msec = t.msec - 1'b1;
      end else begin
         r.msec = MSEC_W'(MSEC_MAX);
         if (t.sec != '0) begin
            r.sec = t.sec - 1'b1;
         end else begin
            r.sec = SEC_W'(SEC_MAX);
            if (t.min != '0) begin
               r.min = t.min - 1'b1;
            end else begin
               r.min  = MIN_W'(MIN_MAX);
               r.hour = (t.hour == '0) ? hour_max : t.hour - 1'b1;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - enabled prescaler producing one tick every DIV enabled cycles
module tick_gen #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == CW'(DIV - 1));

   // Count only while enabled so a paused run keeps its sub-tick phase.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/stopwatch_lap_timer.sv
// rtl/stopwatch_lap_timer.sv - up/down hh:mm:ss.cc timer with lap FIFO (LAP_OVERWRITE_EN: overwrite oldest lap when full)
module stopwatch_lap_timer
   import time_pkg::*;
#(
   parameter int CLK_HZ    = 100_000_000,
   parameter int TICK_HZ   = 100,
   parameter int LAP_DEPTH = 8,
   parameter int HOUR_W    = 5,
   parameter int HOUR_MAX  = 23
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_runstop,
   input  logic                         i_clear,
   input  logic                         i_lap,
   input  logic                         i_dir,
   input  logic [5:0]                   i_preset_min,
   input  logic                         i_lap_pop,
   output logic [6:0]                   msec,
   output logic [5:0]                   sec,
   output logic [5:0]                   min,
   output logic [HOUR_W-1:0]            hour,
   output logic                         running,
   output logic                         expired,
   output logic                         lap_valid,
   output logic [6:0]                   lap_msec,
   output logic [5:0]                   lap_sec,
   output logic [5:0]                   lap_min,
   output logic [HOUR_W-1:0]            lap_hour,
   output logic [$clog2(LAP_DEPTH):0]   lap_count
);

   localparam int AW = $clog2(LAP_DEPTH);
   localparam logic [HOUR_FW-1:0] HMAX = HOUR_FW'(HOUR_MAX);

   state_t             state, state_next;
   time_t              t_q, t_next, preset, head_q, head_next;
   logic               dir_q, expired_next, tick;
   logic [AW-1:0]      wr_ptr, rd_ptr, rd_next;
   logic [AW:0]        cnt, cnt_next;
   logic               full, push_req, pop_ok, do_write, drop_old;
   time_t              mem [LAP_DEPTH];

   tick_gen #(.DIV(CLK_HZ / TICK_HZ)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (state == RUN),
      .clr  (i_clear),
      .tick (tick)
   );

   assign preset = '{hour: '0, min: i_preset_min, sec: '0, msec: '0};

   // Next state and next time: clear dominates, expiry dominates a same-cycle runstop.
   always_comb begin
      state_next   = state;
      t_next       = t_q;
      expired_next = 1'b0;
      if (i_clear) begin
         state_next = IDLE;
         t_next     = i_dir ? preset : '0;
      end else begin
         case (state)
            IDLE: if (i_runstop) state_next = RUN;
            RUN: begin
               if (i_runstop) state_next = STOP;
               if (tick) begin
                  if (!dir_q) begin
                     t_next = time_inc(t_q, HMAX);
                  end else begin
                     if (t_q != '0) t_next = time_dec(t_q, HMAX);
                     if (t_next == '0) begin
                        state_next   = EXPIRED;
                        expired_next = 1'b1;
                     end
                  end
               end
            end
            STOP: if (i_runstop) state_next = RUN;
            default: ;
         endcase
      end
   end

   // State, live time and the direction latched while idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         t_q     <= '0;
         expired <= 1'b0;
         dir_q   <= 1'b0;
      end else begin
         state   <= state_next;
         t_q     <= t_next;
         expired <= expired_next;
         if (state == IDLE || i_clear) dir_q <= i_dir;
      end
   end

   assign full     = (cnt == (AW+1)'(LAP_DEPTH));
   assign push_req = i_lap && (state == RUN) && !i_clear;
   assign pop_ok   = i_lap_pop && (cnt != '0) && !i_clear;

`ifdef LAP_OVERWRITE_EN
   assign do_write = push_req;
   assign drop_old = push_req && full && !pop_ok;
`else
   assign do_write = push_req && (!full || pop_ok);
   assign drop_old = 1'b0;
`endif

   // Next read pointer, occupancy and head entry, bypassing a write that lands on the new head.
   always_comb begin
      rd_next   = rd_ptr;
      cnt_next  = cnt;
      head_next = '0;
      if (pop_ok || drop_old) rd_next = rd_ptr + 1'b1;
      if (do_write && !(pop_ok || drop_old)) cnt_next = cnt + 1'b1;
      else if (!do_write && pop_ok)          cnt_next = cnt - 1'b1;
      if (cnt_next != '0) head_next = (do_write && wr_ptr == rd_next) ? t_q : mem[rd_next];
   end

   // FIFO pointers and the registered head view; clear flushes everything.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         head_q    <= '0;
         lap_valid <= 1'b0;
      end else if (i_clear) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         head_q    <= '0;
         lap_valid <= 1'b0;
      end else begin
         if (do_write) wr_ptr <= wr_ptr + 1'b1;
         rd_ptr    <= rd_next;
         cnt       <= cnt_next;
         head_q    <= head_next;
         lap_valid <= (cnt_next != '0);
      end
   end

   // Lap storage holds the pre-tick time of the capture cycle.
   always_ff @(posedge clk) begin
      if (do_write) mem[wr_ptr] <= t_q;
   end

   assign msec      = t_q.msec;
   assign sec       = t_q.sec;
   assign min       = t_q.min;
   assign hour      = HOUR_W'(t_q.hour);
   assign running   = (state == RUN);
   assign lap_msec  = head_q.msec;
   assign lap_sec   = head_q.sec;
   assign lap_min   = head_q.min;
   assign lap_hour  = HOUR_W'(head_q.hour);
   assign lap_count = cnt;

endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// tb/tb_stopwatch_lap_timer.sv - vector table, corner sequences and random run against a reference model
module tb_stopwatch_lap_timer;
   import time_pkg::*;

   localparam int DIV   = 10;
   localparam int DEPTH = 4;
   localparam int DAY   = 24 * 360000;
`ifdef LAP_OVERWRITE_EN
   localparam bit OVW = 1'b1;
`else
   localparam bit OVW = 1'b0;
`endif

   logic       clk = 1'b0, rst = 1'b0;
   logic       runstop = 1'b0, clear = 1'b0, lap = 1'b0, dir = 1'b0, pop = 1'b0;
   logic [5:0] pmin = 6'd0;
   logic [6:0] msec, lap_msec;
   logic [5:0] sec, min, lap_sec, lap_min;
   logic [4:0] hour, lap_hour;
   logic       running, expired, lap_valid;
   logic [2:0] lap_count;

   int checks = 0, errors = 0;
   bit mchk = 1'b0;

   always #5 clk = ~clk;

   stopwatch_lap_timer #(
      .CLK_HZ(10), .TICK_HZ(1), .LAP_DEPTH(DEPTH), .HOUR_W(5), .HOUR_MAX(23)
   ) dut (
      .clk(clk), .rst(rst), .i_runstop(runstop), .i_clear(clear), .i_lap(lap),
      .i_dir(dir), .i_preset_min(pmin), .i_lap_pop(pop),
      .msec(msec), .sec(sec), .min(min), .hour(hour), .running(running),
      .expired(expired), .lap_valid(lap_valid), .lap_msec(lap_msec),
      .lap_sec(lap_sec), .lap_min(lap_min), .lap_hour(lap_hour), .lap_count(lap_count)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int to_cc(input int h, input int m, input int s, input int c);
      return h * 360000 + m * 6000 + s * 100 + c;
   endfunction

   function automatic longint pack(input int r, input int e, input int t, input int lv,
                                   input int lt, input int n);
      return (longint'(((r * 2 + e) * 2 + lv) * 8 + n) << 48) | (longint'(t) << 24) | longint'(lt);
   endfunction

   function automatic int dut_tot();
      return to_cc(int'(hour), int'(min), int'(sec), int'(msec));
   endfunction

   function automatic longint dut_pack();
      return pack(int'(running), int'(expired), dut_tot(), int'(lap_valid),
                  to_cc(int'(lap_hour), int'(lap_min), int'(lap_sec), int'(lap_msec)), int'(lap_count));
   endfunction

   // Reference model: total centiseconds, a lap queue and a mode number (0 idle,1 run,2 stop,3 done).
   int m_mode = 0, m_tot = 0, m_div = 0, m_dir = 0, m_exp = 0;
   int m_q[$];

   task automatic model_step();
      bit push, pp, tick;
      int nm;
      m_exp = 0;
      if (clear) begin
         m_mode = 0;
         m_tot  = dir ? int'(pmin) * 6000 : 0;
         m_div  = 0;
         m_dir  = int'(dir);
         m_q.delete();
         return;
      end
      push = lap && (m_mode == 1);
      pp   = pop && (m_q.size() > 0);
      if (pp) void'(m_q.pop_front());
      if (push) begin
         if (m_q.size() < DEPTH) m_q.push_back(m_tot);
         else if (OVW) begin
            void'(m_q.pop_front());
            m_q.push_back(m_tot);
         end
      end
      tick = 1'b0;
      if (m_mode == 1) begin
         if (m_div == DIV - 1) begin
            m_div = 0;
            tick  = 1'b1;
         end else m_div++;
      end
      if (m_mode == 0) m_dir = int'(dir);
      case (m_mode)
         0: if (runstop) m_mode = 1;
         1: begin
            nm = runstop ? 2 : 1;
            if (tick) begin
               if (m_dir == 0) m_tot = (m_tot + 1) % DAY;
               else begin
                  if (m_tot > 0) m_tot--;
                  if (m_tot == 0) begin
                     nm    = 3;
                     m_exp = 1;
                  end
               end
            end
            m_mode = nm;
         end
         2: if (runstop) m_mode = 1;
         default: ;
      endcase
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_mode = 0; m_tot = 0; m_div = 0; m_dir = 0; m_exp = 0;
         m_q.delete();
      end else model_step();
   end

   function automatic longint model_pack();
      return pack(int'(m_mode == 1), m_exp, m_tot, int'(m_q.size() != 0),
                  (m_q.size() != 0) ? m_q[0] : 0, m_q.size());
   endfunction

   always @(negedge clk) begin
      if (mchk) chk("model", dut_pack(), model_pack());
   end

   task automatic step(input bit rs, input bit cl, input bit lp, input bit pp, input int n);
      runstop = rs; clear = cl; lap = lp; pop = pp;
      @(posedge clk); #1;
      runstop = 1'b0; clear = 1'b0; lap = 1'b0; pop = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit rs, cl, lp, pp;
      int wait_n;
      bit run;
      int tot;
      int cnt;
      int head;
   } vec_t;

   vec_t vt[$];

   initial begin
      #1_500_000;
      $display("FAIL watchdog actual timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      time_t a, r;
      int n;
      bit got;

      vt.push_back('{0,0,0,0,    0, 0,   0, 0,  -1});
      vt.push_back('{1,0,0,0, 1000, 1, 100, 0,  -1});
      vt.push_back('{0,0,1,0,    9, 1, 101, 1, 100});
      vt.push_back('{0,0,1,0,    9, 1, 102, 2, 100});
      vt.push_back('{0,0,1,0,    9, 1, 103, 3, 100});
      vt.push_back('{0,0,1,0,    9, 1, 104, 4, 100});
      vt.push_back('{0,0,1,0,    9, 1, 105, 4, OVW ? 101 : 100});
      vt.push_back('{0,0,0,1,    0, 1, 105, 3, OVW ? 102 : 101});
      vt.push_back('{0,0,0,1,    0, 1, 105, 2, OVW ? 103 : 102});
      vt.push_back('{0,0,0,1,    0, 1, 105, 1, OVW ? 104 : 103});
      vt.push_back('{1,0,0,1,    0, 0, 105, 0,  -1});
      vt.push_back('{0,0,0,1,   49, 0, 105, 0,  -1});
      vt.push_back('{1,0,0,0,    4, 1, 105, 0,  -1});
      vt.push_back('{0,0,0,0,    0, 1, 105, 0,  -1});
      vt.push_back('{0,0,0,0,    0, 1, 106, 0,  -1});
      vt.push_back('{0,0,1,0,    0, 1, 106, 1, 106});
      vt.push_back('{1,1,1,0,    0, 0,   0, 0,  -1});
      vt.push_back('{0,0,0,0,   20, 0,   0, 0,  -1});

      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", dut_pack(), 0);
      rst  = 1'b1;
      mchk = 1'b1;

      foreach (vt[i]) begin
         step(vt[i].rs, vt[i].cl, vt[i].lp, vt[i].pp, vt[i].wait_n);
         chk($sformatf("row%0d_running", i), running, vt[i].run);
         chk($sformatf("row%0d_time", i), dut_tot(), vt[i].tot);
         chk($sformatf("row%0d_lap_count", i), lap_count, vt[i].cnt);
         chk($sformatf("row%0d_lap_valid", i), lap_valid, vt[i].head >= 0);
         if (vt[i].head >= 0)
            chk($sformatf("row%0d_lap_head", i),
                to_cc(int'(lap_hour), int'(lap_min), int'(lap_sec), int'(lap_msec)), vt[i].head);
      end

      a = '{hour: 8'd0, min: 6'd59, sec: 6'd59, msec: 7'd99};
      r = time_inc(a, 8'd23);
      chk("inc_hour_carry", to_cc(int'(r.hour), int'(r.min), int'(r.sec), int'(r.msec)), 360000);
      a = '{hour: 8'd23, min: 6'd59, sec: 6'd59, msec: 7'd99};
      r = time_inc(a, 8'd23);
      chk("inc_full_wrap", longint'(r), 0);
      a = '{hour: 8'd1, min: 6'd0, sec: 6'd0, msec: 7'd0};
      r = time_dec(a, 8'd23);
      chk("dec_hour_borrow", to_cc(int'(r.hour), int'(r.min), int'(r.sec), int'(r.msec)), 359999);

      dir = 1'b1; pmin = 6'd1;
      step(0, 1, 0, 0, 0);
      chk("preset_load", dut_tot(), 6000);
      step(1, 0, 0, 0, 0);
      n = 0; got = 1'b0;
      for (int k = 0; k < 60010; k++) begin
         @(posedge clk); #1;
         n++;
         if (expired) begin
            got = 1'b1;
            break;
         end
      end
      chk("expire_seen", got, 1);
      chk("expire_latency", n, 60000);
      chk("expire_time", dut_tot(), 0);
      chk("expire_running", running, 0);
      step(0, 0, 0, 0, 0);
      chk("expire_one_cycle", expired, 0);
      step(1, 0, 0, 0, 20);
      chk("expired_ignores_runstop", running, 0);
      chk("expired_time_held", dut_tot(), 0);
      step(0, 1, 0, 0, 0);
      chk("clear_restores_preset", dut_tot(), 6000);

      pmin = 6'd0;
      step(0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 9);
      chk("zero_preset_running", running, 1);
      chk("zero_preset_no_pulse", expired, 0);
      step(0, 0, 0, 0, 0);
      chk("zero_preset_pulse", expired, 1);
      chk("zero_preset_state", running, 0);

      dir = 1'b0;
      step(0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 37);
      step(0, 0, 1, 0, 3);
      #3 rst = 1'b0;
      #1;
      chk("async_reset", dut_pack(), 0);
      @(posedge clk); #1;
      rst = 1'b1;

      for (int k = 0; k < 3000; k++) begin
         runstop = ($urandom_range(0, 19) == 0);
         clear   = ($urandom_range(0, 149) == 0);
         lap     = ($urandom_range(0, 5) == 0);
         pop     = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 49) == 0) dir = ~dir;
         if (clear) pmin = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 59));
         @(posedge clk); #1;
      end
      runstop = 1'b0; clear = 1'b0; lap = 1'b0; pop = 1'b0;
      @(posedge clk); #1;
      mchk = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
